// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder model: accepts a TRIG pulse and answers with an ECHO pulse
// whose width (in microseconds) is taken from echo_us at the moment the
// trigger is accepted. Intended for on-board loopback of the sensor path.
module hcsr04_echo_emulator #(
    parameter int unsigned CLK_HZ      = 27_000_000,
    parameter int unsigned MIN_TRIG_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned MAX_ECHO_US = 38000,
    parameter int unsigned HOLDOFF_US  = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig,
    input  logic [15:0] echo_us,
    output logic        echo,
    output logic        busy,
    output logic        meas_done,
    output logic        trig_err
);

    localparam int unsigned CYC_PER_US   = CLK_HZ / 1_000_000;
    localparam int unsigned MAX_ECHO_CYC = MAX_ECHO_US * CYC_PER_US;
    localparam int unsigned MIN_TRIG_CYC = MIN_TRIG_US * CYC_PER_US;
    // One down-counter serves BURST, ECHO and HOLDOFF; BURST and HOLDOFF
    // durations are expected to fit in the width sized for the longest echo.
    localparam int unsigned CNT_W        = $clog2(MAX_ECHO_CYC + 1);
    localparam int unsigned HI_W         = $clog2(MIN_TRIG_CYC + 2);

    localparam logic [CNT_W-1:0] BURST_LOAD   = CNT_W'(BURST_US * CYC_PER_US - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_US * CYC_PER_US - 1);
    localparam logic [HI_W-1:0]  HI_MIN       = HI_W'(MIN_TRIG_CYC);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t            state;
    logic              trig_m;
    logic              trig_s;
    logic              trig_s_q;
    logic              trig_rise;
    logic              trig_fall;
    logic [HI_W-1:0]   hi_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  echo_cyc;
    logic [31:0]       w_us;
    logic [CNT_W-1:0]  w_cyc;

    // Two-flop synchronizer for the asynchronous trigger plus an edge-detect stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_m   <= 1'b0;
            trig_s   <= 1'b0;
            trig_s_q <= 1'b0;
        end else begin
            trig_m   <= trig;
            trig_s   <= trig_m;
            trig_s_q <= trig_s;
        end
    end

    assign trig_rise = trig_s & ~trig_s_q;
    assign trig_fall = ~trig_s & trig_s_q;

    // Requested width with the zero / out-of-range clamp, scaled to cycles
    always_comb begin
        w_us = 32'(echo_us);
        if (echo_us == '0 || 32'(echo_us) > MAX_ECHO_US) begin
            w_us = MAX_ECHO_US;
        end
        w_cyc = CNT_W'(w_us * CYC_PER_US);
    end

    // Trigger qualification, burst gap, echo pulse and holdoff sequencing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            echo      <= 1'b0;
            busy      <= 1'b0;
            meas_done <= 1'b0;
            trig_err  <= 1'b0;
            hi_cnt    <= '0;
            cnt       <= '0;
            echo_cyc  <= '0;
        end else begin
            meas_done <= 1'b0;
            trig_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trig_rise) begin
                        state  <= ARM;
                        busy   <= 1'b1;
                        hi_cnt <= HI_W'(1);
                    end
                end
                ARM: begin
                    if (trig_fall) begin
                        if (hi_cnt >= HI_MIN) begin
                            state    <= BURST;
                            echo_cyc <= w_cyc;
                            cnt      <= BURST_LOAD;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            trig_err <= 1'b1;
                        end
                    end else if (trig_s && hi_cnt != '1) begin
                        hi_cnt <= hi_cnt + HI_W'(1);
                    end
                end
                BURST: begin
                    if (cnt == '0) begin
                        state <= ECHO;
                        echo  <= 1'b1;
                        cnt   <= echo_cyc - CNT_W'(1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ECHO: begin
                    if (cnt == '0) begin
                        state     <= HOLDOFF;
                        echo      <= 1'b0;
                        meas_done <= 1'b1;
                        cnt       <= HOLDOFF_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Bench for hcsr04_echo_emulator. Runs at CLK_HZ=4 MHz (4 cycles/us) with
// MAX_ECHO_US=1000 and HOLDOFF_US=100 so clamped echoes stay short.
module tb_hcsr04_echo_emulator;

    localparam int CYC        = 4;
    localparam int MIN_CYC    = 10 * CYC;     // 40
    localparam int BURST_CYC  = 200 * CYC;    // 800
    localparam int HOLD_CYC   = 100 * CYC;    // 400
    localparam int MAX_CYC    = 1000 * CYC;   // 4000
    localparam int LAT_EXP    = 3 + BURST_CYC;

    logic        clk;
    logic        rst_n;
    logic        trig;
    logic [15:0] echo_us;
    logic        echo;
    logic        busy;
    logic        meas_done;
    logic        trig_err;

    hcsr04_echo_emulator #(
        .CLK_HZ      (4_000_000),
        .MIN_TRIG_US (10),
        .BURST_US    (200),
        .MAX_ECHO_US (1000),
        .HOLDOFF_US  (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .echo_us   (echo_us),
        .echo      (echo),
        .busy      (busy),
        .meas_done (meas_done),
        .trig_err  (trig_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Free-running pulse tallies; tests take differences between snapshots
    int md_total   = 0;
    int err_total  = 0;
    int both_total = 0;
    always @(negedge clk) begin
        if (meas_done) md_total++;
        if (trig_err) err_total++;
        if (meas_done && trig_err) both_total++;
    end

    typedef struct {
        int          hi;
        logic [15:0] us;
        bit          accept;
        int          width;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_trig(input int hi, input logic [15:0] us);
        @(negedge clk);
        echo_us = us;
        trig    = 1'b1;
        repeat (hi) @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_echo(output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (echo) begin
                n    = i;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic measure_width(output int w);
        w = 0;
        while (echo && w < 20000) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic measure_tail(output int t);
        t = 0;
        while (busy && t < 5000) begin
            t++;
            @(negedge clk);
        end
    endtask

    task automatic watch_quiet(input int n, output int active);
        active = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (echo || busy) active++;
        end
    endtask

    initial begin
        int  lat, width, tail, err_at, active, md0, err0;
        bit  seen;

        vecs[0] = '{hi: 40, us: 16'd580,   accept: 1'b1, width: 2320};
        vecs[1] = '{hi: 39, us: 16'd580,   accept: 1'b0, width: 0};
        vecs[2] = '{hi: 60, us: 16'd0,     accept: 1'b1, width: 4000};
        vecs[3] = '{hi: 45, us: 16'd50000, accept: 1'b1, width: 4000};
        vecs[4] = '{hi: 41, us: 16'd1000,  accept: 1'b1, width: 4000};
        vecs[5] = '{hi: 40, us: 16'd1001,  accept: 1'b1, width: 4000};
        vecs[6] = '{hi: 50, us: 16'd1,     accept: 1'b1, width: 4};
        vecs[7] = '{hi: 1,  us: 16'd5,     accept: 1'b0, width: 0};

        rst_n   = 1'b0;
        trig    = 1'b0;
        echo_us = '0;
        repeat (3) @(negedge clk);
        check("reset_echo", int'(echo), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_meas_done", int'(meas_done), 0);
        check("reset_trig_err", int'(trig_err), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            md0  = md_total;
            err0 = err_total;
            send_trig(vecs[v].hi, vecs[v].us);
            if (vecs[v].accept) begin
                wait_echo(lat, seen);
                check($sformatf("v%0d_latency", v), lat, LAT_EXP);
                measure_width(width);
                check($sformatf("v%0d_width", v), width, vecs[v].width);
                measure_tail(tail);
                check($sformatf("v%0d_busy_tail", v), tail, HOLD_CYC);
                check($sformatf("v%0d_meas_done", v), md_total - md0, 1);
                check($sformatf("v%0d_trig_err", v), err_total - err0, 0);
            end else begin
                err_at = -1;
                active = 0;
                for (int i = 1; i <= 30; i++) begin
                    @(negedge clk);
                    if (trig_err && err_at < 0) err_at = i;
                    if (echo) active++;
                end
                check($sformatf("v%0d_err_at", v), err_at, 3);
                check($sformatf("v%0d_err_count", v), err_total - err0, 1);
                check($sformatf("v%0d_echo_quiet", v), active, 0);
                check($sformatf("v%0d_busy_idle", v), int'(busy), 0);
                check($sformatf("v%0d_meas_done", v), md_total - md0, 0);
            end
            repeat (5) @(negedge clk);
        end

        // Width latched at acceptance; trig activity after it is ignored
        md0  = md_total;
        err0 = err_total;
        send_trig(MIN_CYC, 16'd1);
        repeat (100) @(negedge clk);
        echo_us = 16'd900;
        wait_echo(lat, seen);
        check("latch_echo_seen", int'(seen), 1);
        trig = 1'b1;
        measure_width(width);
        check("latch_width", width, 4);
        repeat (10) @(negedge clk);
        trig = 1'b0;
        repeat (10) @(negedge clk);
        trig = 1'b1;
        repeat (60) @(negedge clk);
        trig = 1'b0;
        measure_tail(tail);
        watch_quiet(1000, active);
        check("latch_no_retrigger", active, 0);
        check("latch_meas_done", md_total - md0, 1);
        check("latch_no_trig_err", err_total - err0, 0);

        // Trig held high across the end of holdoff needs a fresh rising edge
        md0 = md_total;
        send_trig(MIN_CYC, 16'd2);
        wait_echo(lat, seen);
        trig = 1'b1;
        measure_width(width);
        check("hold_width", width, 8);
        measure_tail(tail);
        check("hold_tail", tail, HOLD_CYC);
        watch_quiet(500, active);
        check("hold_level_ignored", active, 0);
        trig = 1'b0;
        repeat (5) @(negedge clk);
        send_trig(MIN_CYC, 16'd3);
        wait_echo(lat, seen);
        check("hold_retrig_latency", lat, LAT_EXP);
        measure_width(width);
        check("hold_retrig_width", width, 12);
        measure_tail(tail);
        check("hold_meas_done", md_total - md0, 2);

        // Reset pulse in the middle of an echo
        send_trig(MIN_CYC, 16'd580);
        wait_echo(lat, seen);
        repeat (100) @(negedge clk);
        md0 = md_total;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_echo", int'(echo), 0);
        check("rst_mid_busy", int'(busy), 0);
        rst_n = 1'b1;
        watch_quiet(3000, active);
        check("rst_quiet", active, 0);
        check("rst_no_meas_done", md_total - md0, 0);
        md0 = md_total;
        send_trig(MIN_CYC, 16'd7);
        wait_echo(lat, seen);
        check("rst_after_latency", lat, LAT_EXP);
        measure_width(width);
        check("rst_after_width", width, 28);
        measure_tail(tail);
        check("rst_after_meas_done", md_total - md0, 1);

        check("md_err_overlap", both_total, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
